hazard_scoreboard_forwarder: RTL
================================

Name: hazard_scoreboard_forwarder

Overview:
- Next-generation hazard/forwarding unit for the pipelined core with non-blocking, variable-latency loads.
- Computes per-operand bypass selects for NUM_SRC decode operands and keeps store-data forwarding in M.
- Tracks outstanding load destinations in an in-order tag FIFO (scoreboard) and raises decode/M stalls until load data returns.
- Sits beside the decode/execute/memory stage registers; drives only mux selects and stall lines.

Parameters:
- NUM_SRC, 2, number of decode source operands checked (rs1, rs2, optionally rs3).
- MAX_OUTSTANDING, 4, load tag FIFO depth; power of two, >=2.
- NUM_REGS, 32, architectural register count; REG_AW = $clog2(NUM_REGS).

Ports:
- clk  in  1  core clock.
- rst_n  in  1  async active-low reset.
- src_rs  in  NUM_SRC x REG_AW  decode source register indices.
- src_used  in  NUM_SRC  operand actually read.
- rd_m  in  REG_AW  destination in M.
- regwrite_m  in  1  M writes rd_m with ALU result.
- memaccess_m  in  memaccess_t  M access type.
- rs2_m  in  REG_AW  store-data source in M.
- rd_w  in  REG_AW  destination in W.
- regwrite_w  in  1  W writes rd_w.
- load_issue  in  1  load in M accepted by memory this cycle (rd_m is its destination).
- load_resp_valid  in  1  oldest outstanding load returns data this cycle.
- fwd_sel  out  NUM_SRC x fwd_sel_t  per-operand bypass select.
- stall_d  out  1  hold decode.
- store_fwd_m  out  1  store data taken from W result.
- store_stall_m  out  1  hold M (store data not yet available).
- load_full  out  1  FIFO full; memory stage must not issue.
- resp_rd  out  REG_AW  destination of returning load (valid with load_resp_valid).
- pending_cnt  out  $clog2(MAX_OUTSTANDING+1)  outstanding load count.
- err_overflow  out  1  sticky: issue while full.
- err_underflow  out  1  sticky: response while empty.

Behaviour:
- Reset (rst_n low, async): FIFO emptied, pending_cnt=0, err flags 0. Combinational outputs then read fwd_sel=FWD_RF, stall_d=0, store_fwd_m=0, store_stall_m=0, load_full=0, resp_rd=0.
- Tag FIFO: push rd_m on load_issue when rd_m!=0 and not full. Pop oldest on load_resp_valid when not empty. Both act on the clk rising edge.
- load_issue with rd_m==0: no push, no error.
- Simultaneous push and pop: both happen; pending_cnt unchanged; legal even when full.
- Push while full and no pop: dropped; err_overflow set.
- Pop while empty: ignored; err_underflow set; resp_rd=0.
- Errors clear only on reset.
- Pointers wrap modulo MAX_OUTSTANDING. Full and empty are derived from pending_cnt.
- resp_rd = head entry, combinational.
- busy(r) = r!=0 and some valid FIFO entry equals r. Duplicate tags are allowed; the register stays busy until the last matching entry pops.
- Per operand i, if src_used[i]=0 or src_rs[i]==0 then FWD_RF and no stall. Otherwise, first match wins:
  - load_resp_valid and resp_rd==src: FWD_LRESP.
  - busy(src) (not covered above): stall.
  - memaccess_m==MEM_READ and rd_m==src: stall (load-use).
  - regwrite_m and rd_m==src: FWD_M.
  - regwrite_w and rd_w==src: FWD_W.
  - else FWD_RF.
- stall_d = OR over operands of their stall condition.
- Store path (memaccess_m==MEM_WRITE, rs2_m!=0):
  - busy(rs2_m) and not (load_resp_valid and resp_rd==rs2_m): store_stall_m=1.
  - else regwrite_w and rd_w==rs2_m: store_fwd_m=1.
- Timing: all decisions are same-cycle combinational from inputs and registered FIFO state. A push affects busy from the next cycle.

Decomposition:
- riscv_defines package:
  - add fwd_sel_t enum {FWD_RF, FWD_M, FWD_W, FWD_LRESP}.
  - reuse memaccess_t (MEM_READ, MEM_WRITE).
- Sub-module load_tag_fifo: parametrised depth/width; push, pop, head, count, full, empty, per-entry valid/data vectors for the busy compare.
- Top level holds the compare/priority logic.

Test Plan:
- Reset mid-operation: 3 loads outstanding (rd=5,6,7), assert rst_n=0 -> pending_cnt=0, stall_d=0, err flags 0 immediately; busy cleared after release.
- Load-use: load_issue rd_m=5, next cycle src_rs[0]=5 -> stall_d=1 until the cycle load_resp_valid with resp_rd=5, where fwd_sel[0]=FWD_LRESP and stall_d=0.
- Priority: regwrite_m rd_m=3, regwrite_w rd_w=3, src_rs[1]=3 -> FWD_M. src_rs[0]=0 -> FWD_RF with no stall.
- Fill/overflow: 4 issues (rd=1..4) -> load_full=1, pending_cnt=4. 5th issue alone -> err_overflow=1, count stays 4. Issue+response same cycle while full -> count 4, head advances.
- Store data: MEM_WRITE rs2_m=9, regwrite_w rd_w=9 -> store_fwd_m=1. With rd 9 outstanding -> store_stall_m=1 until its response.
- Duplicate tags: issue rd=8 twice; one response -> src 8 still stalls; second response -> FWD_LRESP, then FWD_RF.

Source files
------------

// File: rtl/riscv_defines.sv
// Shared core definitions: memory access kinds and operand bypass selects.
package riscv_defines;

  typedef enum logic [1:0] {
    MEM_NONE,
    MEM_READ,
    MEM_WRITE
  } memaccess_t;

  typedef enum logic [1:0] {
    FWD_RF,
    FWD_M,
    FWD_W,
    FWD_LRESP
  } fwd_sel_t;

endpackage

// File: rtl/load_tag_fifo.sv
// In-order FIFO of outstanding load destination tags, exposing every slot
// plus its valid bit so the caller can search for busy registers.
module load_tag_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 5,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head,
  output logic [CNT_W-1:0]             count,
  output logic                         full,
  output logic                         empty,
  output logic [DEPTH-1:0]             entry_valid,
  output logic [DEPTH-1:0][WIDTH-1:0]  entry_data,
  output logic                         err_overflow,
  output logic                         err_underflow
);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [PTR_W-1:0]            rd_ptr;
  logic [PTR_W-1:0]            wr_ptr;
  logic                        do_push;
  logic                        do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      if (push && full && !do_pop) err_overflow  <= 1'b1;
      if (pop && empty)            err_underflow <= 1'b1;
    end
  end

  // NOTE: storage has no reset; stale slots are masked by entry_valid and head.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head       = empty ? '0 : mem[rd_ptr];
  assign entry_data = mem;

  // A slot is live when its distance from the read pointer is below the count.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entry_valid[i] = CNT_W'(PTR_W'(PTR_W'(i) - rd_ptr)) < count;
    end
  end

endmodule

// File: rtl/hazard_scoreboard_forwarder.sv
// Hazard/forwarding unit: decode bypass selects, load-use and scoreboard stalls,
// and store-data forwarding in M, with outstanding loads tracked in a tag FIFO.
module hazard_scoreboard_forwarder
  import riscv_defines::*;
#(
  parameter  int NUM_SRC         = 2,
  parameter  int MAX_OUTSTANDING = 4,
  parameter  int NUM_REGS        = 32,
  localparam int REG_AW          = $clog2(NUM_REGS),
  localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_SRC-1:0][REG_AW-1:0] src_rs,
  input  logic [NUM_SRC-1:0]             src_used,
  input  logic [REG_AW-1:0]              rd_m,
  input  logic                           regwrite_m,
  input  memaccess_t                     memaccess_m,
  input  logic [REG_AW-1:0]              rs2_m,
  input  logic [REG_AW-1:0]              rd_w,
  input  logic                           regwrite_w,
  input  logic                           load_issue,
  input  logic                           load_resp_valid,
  output fwd_sel_t [NUM_SRC-1:0]         fwd_sel,
  output logic                           stall_d,
  output logic                           store_fwd_m,
  output logic                           store_stall_m,
  output logic                           load_full,
  output logic [REG_AW-1:0]              resp_rd,
  output logic [CNT_W-1:0]               pending_cnt,
  output logic                           err_overflow,
  output logic                           err_underflow
);

  logic [MAX_OUTSTANDING-1:0]             entry_valid;
  logic [MAX_OUTSTANDING-1:0][REG_AW-1:0] entry_data;
  logic                                   fifo_empty;
  logic                                   resp_live;

  load_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (REG_AW)
  ) u_tag_fifo (
    .clk           (clk),
    .rst_n         (rst_n),
    .push          (load_issue && (rd_m != '0)),
    .push_data     (rd_m),
    .pop           (load_resp_valid),
    .head          (resp_rd),
    .count         (pending_cnt),
    .full          (load_full),
    .empty         (fifo_empty),
    .entry_valid   (entry_valid),
    .entry_data    (entry_data),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow)
  );

  // A response only carries a tag when something is actually outstanding.
  assign resp_live = load_resp_valid && !fifo_empty;

  function automatic logic tag_busy(
    input logic [REG_AW-1:0]                  r,
    input logic [MAX_OUTSTANDING-1:0]             v,
    input logic [MAX_OUTSTANDING-1:0][REG_AW-1:0] d
  );
    logic hit;
    hit = 1'b0;
    for (int e = 0; e < MAX_OUTSTANDING; e++) begin
      if (v[e] && (d[e] == r)) hit = 1'b1;
    end
    return hit && (r != '0);
  endfunction

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    stall_d = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      fwd_sel[i] = FWD_RF;
      if (src_used[i] && (src_rs[i] != '0)) begin
        if (resp_live && (resp_rd == src_rs[i])) begin
          fwd_sel[i] = FWD_LRESP;
        end else if (tag_busy(src_rs[i], entry_valid, entry_data)) begin
          stall_d = 1'b1;
        end else if ((memaccess_m == MEM_READ) && (rd_m == src_rs[i])) begin
          stall_d = 1'b1;
        end else if (regwrite_m && (rd_m == src_rs[i])) begin
          fwd_sel[i] = FWD_M;
        end else if (regwrite_w && (rd_w == src_rs[i])) begin
          fwd_sel[i] = FWD_W;
        end
      end
    end
  end

  always_comb begin
    store_fwd_m   = 1'b0;
    store_stall_m = 1'b0;
    if ((memaccess_m == MEM_WRITE) && (rs2_m != '0)) begin
      if (tag_busy(rs2_m, entry_valid, entry_data) &&
          !(resp_live && (resp_rd == rs2_m))) begin
        store_stall_m = 1'b1;
      end else if (regwrite_w && (rd_w == rs2_m)) begin
        store_fwd_m = 1'b1;
      end
    end
  end

endmodule
